// File: rtl/interp_mux_sequencer.sv
// Select-side sequencer for the sub-pixel interpolation input mux: two-round sel sweep with back-pressure and abort.
// Optional `define SEQ_STALL_CNT_EN adds a saturating stall_cnt output counting ready=0 cycles during sweeps.
module interp_mux_sequencer #(
    parameter int unsigned NUM_PIXEL  = 8,
    parameter int unsigned SEL_W      = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             two_round,
    input  logic             abort,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic             first_round,
    output logic             issue_valid,
    output logic             mux_valid,
    output logic [2:0]       mux_region,
    output logic             busy,
    output logic             done
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int unsigned R1_ROWS = NUM_PIXEL + 8;
    localparam int unsigned R1_COLS = R1_ROWS + NUM_PIXEL;
    localparam int unsigned R1_A    = R1_COLS + NUM_PIXEL;
    localparam int unsigned R1_B    = R1_A + NUM_PIXEL;
    localparam int unsigned R1_LAST = R1_B + NUM_PIXEL - 1;
    localparam int unsigned R2_ROWS = NUM_PIXEL + 3;
    localparam int unsigned R2_COLS = R2_ROWS + NUM_PIXEL;
    localparam int unsigned R2_A    = R2_COLS + NUM_PIXEL;
    localparam int unsigned R2_B    = R2_A + NUM_PIXEL;
    localparam int unsigned R2_LAST = R2_B + NUM_PIXEL - 1;

    typedef enum logic [2:0] {IDLE, ROUND1, GAP, ROUND2, FLUSH} state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] sel_next;
    logic             first_next;
    logic [1:0]       gap_cnt, gap_next;
    logic             two_round_q, tr_next;
    logic             issue;
    logic [2:0]       issue_region;
    logic [SEL_W-1:0] b_rows, b_cols, b_a, b_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= '0;
            first_round <= 1'b1;
            gap_cnt     <= '0;
            two_round_q <= 1'b0;
        end else begin
            state       <= state_next;
            sel         <= sel_next;
            first_round <= first_next;
            gap_cnt     <= gap_next;
            two_round_q <= tr_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        first_next = first_round;
        gap_next   = gap_cnt;
        tr_next    = two_round_q;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ROUND1;
                    sel_next   = '0;
                    first_next = 1'b1;
                    tr_next    = two_round;
                end
            end
            ROUND1: begin
                if (ready) begin
                    issue = 1'b1;
                    if (sel == SEL_W'(R1_LAST)) begin
                        sel_next = '0;
                        if (!two_round_q) begin
                            state_next = FLUSH;
                        end else if (GAP_CYCLES == 0) begin
                            state_next = ROUND2;
                            first_next = 1'b0;
                        end else begin
                            state_next = GAP;
                            gap_next   = '0;
                        end
                    end else begin
                        sel_next = sel + SEL_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 2'(GAP_CYCLES - 1)) begin
                    state_next = ROUND2;
                    sel_next   = '0;
                    first_next = 1'b0;
                end else begin
                    gap_next = gap_cnt + 2'd1;
                end
            end
            ROUND2: begin
                if (ready) begin
                    issue = 1'b1;
                    if (sel == SEL_W'(R2_LAST)) begin
                        sel_next   = '0;
                        state_next = FLUSH;
                    end else begin
                        sel_next = sel + SEL_W'(1);
                    end
                end
            end
            FLUSH: begin
                state_next = IDLE;
                sel_next   = '0;
                first_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // abort overrides everything, including a start seen in IDLE and an issue this cycle
        if (abort) begin
            state_next = IDLE;
            sel_next   = '0;
            first_next = 1'b1;
            gap_next   = '0;
            tr_next    = two_round_q;
            issue      = 1'b0;
        end
    end

    always_comb begin
        b_rows = first_round ? SEL_W'(R1_ROWS) : SEL_W'(R2_ROWS);
        b_cols = first_round ? SEL_W'(R1_COLS) : SEL_W'(R2_COLS);
        b_a    = first_round ? SEL_W'(R1_A)    : SEL_W'(R2_A);
        b_b    = first_round ? SEL_W'(R1_B)    : SEL_W'(R2_B);
        if (sel < b_rows)      issue_region = 3'd0;
        else if (sel < b_cols) issue_region = 3'd1;
        else if (sel < b_a)    issue_region = 3'd2;
        else if (sel < b_b)    issue_region = 3'd3;
        else                   issue_region = 3'd4;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mux_valid  <= 1'b0;
            mux_region <= 3'd0;
        end else begin
            mux_valid <= issue;
            if (issue) begin
                mux_region <= issue_region;
            end
        end
    end

    assign issue_valid = issue;
    assign busy        = (state != IDLE);
    assign done        = (state == FLUSH);

`ifdef SEQ_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start && !abort) begin
            stall_cnt <= '0;
        end else if ((state == ROUND1 || state == ROUND2) && !ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_interp_mux_sequencer.sv
// Directed self-checking bench for interp_mux_sequencer (default parameters, GAP_CYCLES=1).
module tb_interp_mux_sequencer;

    logic       clock, reset, start, two_round, abort, ready;
    logic [7:0] sel;
    logic       first_round, issue_valid, mux_valid, busy, done;
    logic [2:0] mux_region;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    interp_mux_sequencer #(.NUM_PIXEL(8), .SEL_W(8), .GAP_CYCLES(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .two_round   (two_round),
        .abort       (abort),
        .ready       (ready),
        .sel         (sel),
        .first_round (first_round),
        .issue_valid (issue_valid),
        .mux_valid   (mux_valid),
        .mux_region  (mux_region),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hand-derived region boundaries for NUM_PIXEL=8
    function automatic logic [2:0] exp_region(input int s, input bit r1);
        if (r1) begin
            if (s < 16) return 3'd0;
            if (s < 24) return 3'd1;
            if (s < 32) return 3'd2;
            if (s < 40) return 3'd3;
            return 3'd4;
        end
        if (s < 11) return 3'd0;
        if (s < 19) return 3'd1;
        if (s < 27) return 3'd2;
        if (s < 35) return 3'd3;
        return 3'd4;
    endfunction

    task automatic test_reset;
        checks++;
        if ({sel, first_round, issue_valid, mux_valid, mux_region, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: sel=%0d fr=%b iv=%b mv=%b reg=%0d busy=%b done=%b", sel, first_round, issue_valid, mux_valid, mux_region, busy, done);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b iv=%b expected 0 0", busy, issue_valid);
        end
    endtask

    task automatic test_single_round;
        int mv = 0;
        int dn = 0;
        @(negedge clock);
        start = 1'b1; two_round = 1'b0; ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (issue_valid !== 1'b1 || sel !== 8'(i) || first_round !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL r1_issue[%0d]: iv=%b sel=%0d fr=%b done=%b expected 1 %0d 1 0", i, issue_valid, sel, first_round, done, i);
            end
            checks++;
            if ((i == 0) ? (mux_valid !== 1'b0) : (mux_valid !== 1'b1 || mux_region !== exp_region(i - 1, 1'b1))) begin
                failures++;
                $display("FAIL r1_mux[%0d]: mv=%b reg=%0d expected mv=%b reg=%0d", i, mux_valid, mux_region, (i != 0), exp_region(i - 1, 1'b1));
            end
            if (mux_valid) mv++;
            if (done) dn++;
            @(negedge clock);
            #1;
        end
        checks++;
        if ({issue_valid, mux_valid, mux_region, busy, done} !== {1'b0, 1'b1, 3'd4, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL r1_flush: iv=%b mv=%b reg=%0d busy=%b done=%b expected 0 1 4 1 1", issue_valid, mux_valid, mux_region, busy, done);
        end
        if (mux_valid) mv++;
        if (done) dn++;
        @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mux_valid !== 1'b0 || first_round !== 1'b1) begin
            failures++;
            $display("FAIL r1_idle: busy=%b done=%b mv=%b fr=%b expected 0 0 0 1", busy, done, mux_valid, first_round);
        end
        checks++;
        if (mv != 48 || dn != 1) begin
            failures++;
            $display("FAIL r1_counts: mux_valid=%0d done=%0d expected 48 1", mv, dn);
        end
`ifdef SEQ_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL r1_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_two_round;
        int mv = 0;
        int dn = 0;
        @(negedge clock);
        start = 1'b1; two_round = 1'b1; ready = 1'b1;
        @(negedge clock);
        start = 1'b0; two_round = 1'b0;
        #1;
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (issue_valid !== 1'b1 || sel !== 8'(i) || first_round !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL tr1_issue[%0d]: iv=%b sel=%0d fr=%b done=%b expected 1 %0d 1 0", i, issue_valid, sel, first_round, done, i);
            end
            if (mux_valid) mv++;
            if (done) dn++;
            @(negedge clock);
            #1;
        end
        checks++;
        if ({issue_valid, mux_valid, mux_region, first_round, busy, done} !== {1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL gap_cycle: iv=%b mv=%b reg=%0d fr=%b busy=%b done=%b expected 0 1 4 1 1 0", issue_valid, mux_valid, mux_region, first_round, busy, done);
        end
        if (mux_valid) mv++;
        @(negedge clock);
        #1;
        for (int i = 0; i < 43; i++) begin
            checks++;
            if (issue_valid !== 1'b1 || sel !== 8'(i) || first_round !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL r2_issue[%0d]: iv=%b sel=%0d fr=%b done=%b expected 1 %0d 0 0", i, issue_valid, sel, first_round, done, i);
            end
            checks++;
            if ((i == 0) ? (mux_valid !== 1'b0) : (mux_valid !== 1'b1 || mux_region !== exp_region(i - 1, 1'b0))) begin
                failures++;
                $display("FAIL r2_mux[%0d]: mv=%b reg=%0d expected mv=%b reg=%0d", i, mux_valid, mux_region, (i != 0), exp_region(i - 1, 1'b0));
            end
            if (mux_valid) mv++;
            if (done) dn++;
            @(negedge clock);
            #1;
        end
        checks++;
        if ({mux_valid, mux_region, first_round, done} !== {1'b1, 3'd4, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL r2_flush: mv=%b reg=%0d fr=%b done=%b expected 1 4 0 1", mux_valid, mux_region, first_round, done);
        end
        if (mux_valid) mv++;
        if (done) dn++;
        @(negedge clock);
        #1;
        checks++;
        if (mv != 91 || dn != 1 || busy !== 1'b0 || first_round !== 1'b1) begin
            failures++;
            $display("FAIL tr_counts: mux_valid=%0d done=%0d busy=%b fr=%b expected 91 1 0 1", mv, dn, busy, first_round);
        end
    endtask

    task automatic test_back_to_back;
        int iss = 0, mv = 0, dn = 0, fr_bad = 0, cyc = 0, done_at = -1;
        @(negedge clock);
        start = 1'b1; two_round = 1'b0; ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        while (busy && cyc < 300) begin
            if (issue_valid) iss++;
            if (mux_valid) mv++;
            if (done) begin dn++; done_at = cyc; end
            if (!first_round) fr_bad++;
            @(negedge clock);
            start = (cyc == 10);
            two_round = (cyc == 10);
            #1;
            cyc++;
        end
        start = 1'b0; two_round = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_timeout: busy=%b after %0d cycles expected 0", busy, cyc);
        end
        checks++;
        if (iss != 48 || mv != 48 || dn != 1 || done_at != 48 || fr_bad != 0) begin
            failures++;
            $display("FAIL busy_start_ignored: issues=%0d mv=%0d done=%0d done_at=%0d fr0=%0d expected 48 48 1 48 0", iss, mv, dn, done_at, fr_bad);
        end
        @(negedge clock);
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || issue_valid !== 1'b0 || sel !== 8'd0) begin
            failures++;
            $display("FAIL start_abort_idle: busy=%b iv=%b sel=%0d expected 0 0 0", busy, issue_valid, sel);
        end
        @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle2: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure;
        int exp_sel = 0, iss = 0, mv = 0, dn = 0, cyc = 0, nstall = 0, stall_left = -1;
        @(negedge clock);
        start = 1'b1; two_round = 1'b0; ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        while (busy && cyc < 300) begin
            if (issue_valid) begin
                checks++;
                if (sel !== 8'(exp_sel)) begin
                    failures++;
                    $display("FAIL bp_sequence: sel=%0d expected %0d", sel, exp_sel);
                end
                exp_sel++;
                iss++;
            end
            if (mux_valid) mv++;
            if (done) dn++;
            @(negedge clock);
            if (stall_left < 0 && sel == 8'd20) stall_left = 3;
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = 1'b1;
            end
            #1;
            cyc++;
            if (!ready) begin
                nstall++;
                checks++;
                if (issue_valid !== 1'b0 || sel !== 8'd20) begin
                    failures++;
                    $display("FAIL bp_hold: iv=%b sel=%0d expected 0 20", issue_valid, sel);
                end
            end
        end
        ready = 1'b1;
        checks++;
        if (busy !== 1'b0 || iss != 48 || mv != 48 || dn != 1 || nstall != 3) begin
            failures++;
            $display("FAIL bp_counts: busy=%b issues=%0d mv=%0d done=%0d stalls=%0d expected 0 48 48 1 3", busy, iss, mv, dn, nstall);
        end
`ifdef SEQ_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_abort;
        int cyc = 0, mv = 0, dn = 0;
        @(negedge clock);
        start = 1'b1; two_round = 1'b1; ready = 1'b1;
        @(negedge clock);
        start = 1'b0; two_round = 1'b0;
        #1;
        while (!(busy && first_round == 1'b0 && sel == 8'd10) && cyc < 300) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (!(busy && first_round == 1'b0 && sel == 8'd10)) begin
            failures++;
            $display("FAIL abort_reach: busy=%b fr=%b sel=%0d expected 1 0 10", busy, first_round, sel);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_issue: iv=%b expected 0", issue_valid);
        end
        @(negedge clock);
        abort = 1'b0;
        #1;
        checks++;
        if ({busy, sel, first_round, mux_valid, done, issue_valid} !== {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_state: busy=%b sel=%0d fr=%b mv=%b done=%b iv=%b expected 0 0 1 0 0 0", busy, sel, first_round, mux_valid, done, issue_valid);
        end
        repeat (5) begin
            @(negedge clock);
            #1;
            if (done) dn++;
        end
        checks++;
        if (dn != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: done=%0d busy=%b expected 0 0", dn, busy);
        end
        dn = 0; cyc = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        while (busy && cyc < 300) begin
            if (mux_valid) mv++;
            if (done) dn++;
            @(negedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (busy !== 1'b0 || mv != 48 || dn != 1) begin
            failures++;
            $display("FAIL abort_restart: busy=%b mv=%0d done=%0d expected 0 48 1", busy, mv, dn);
        end
    endtask

    task automatic test_async_reset;
        int cyc = 0;
        @(negedge clock);
        start = 1'b1; two_round = 1'b0; ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        while (sel != 8'd30 && cyc < 300) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (sel !== 8'd30 || mux_region !== 3'd2) begin
            failures++;
            $display("FAIL arst_reach: sel=%0d reg=%0d expected 30 2", sel, mux_region);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({sel, first_round, issue_valid, mux_valid, mux_region, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL arst_immediate: sel=%0d fr=%b iv=%b mv=%b reg=%0d busy=%b done=%b", sel, first_round, issue_valid, mux_valid, mux_region, busy, done);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || sel !== 8'd0 || issue_valid !== 1'b0 || mux_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL arst_idle: busy=%b sel=%0d iv=%b mv=%b done=%b expected 0 0 0 0 0", busy, sel, issue_valid, mux_valid, done);
        end
`ifdef SEQ_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL arst_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; two_round = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        test_reset;
        test_single_round;
        test_two_round;
        test_back_to_back;
        test_backpressure;
        test_abort;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
